pc_gen: RTL and testbench
=========================

PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 SHALL have parameter RESET_PC, 32'h0000_3000, PC value loaded on reset.
REQ-002 SHALL have parameter HANDLER_PC, 32'h0000_4180, exception/interrupt entry address.
REQ-003 SHALL have parameter IM_LO / IM_HI, 32'h0000_3000 / 32'h0000_6FFC, legal fetch range, inclusive.
REQ-004 SHALL have parameter RAS_DEPTH, 8, return-address-stack entries (power of 2, 2..64).
REQ-005 SHALL have port clk, in, 1, sole clock, rising edge; one clock domain only.
REQ-006 SHALL have port reset, in, 1, synchronous, active-high.
REQ-007 SHALL have port stall, in, 1, freeze the F-stage PC.
REQ-008 SHALL have port req, in, 1, exception/interrupt request.
REQ-009 SHALL have port eret_d, in, 1, eret in D.
REQ-010 SHALL have port epc, in, 32, return address for eret.
REQ-011 SHALL have port pc_d, in, 32, PC of the D-stage instruction.
REQ-012 SHALL have port imm26, in, 26, j/jal index.
REQ-013 SHALL have port imm16, in, 16, branch offset.
REQ-014 SHALL have port branch_taken, in, 1, D-stage branch resolved taken.
REQ-015 SHALL have port jump, in, 1, j/jal.
REQ-016 SHALL have port link, in, 1, jal/jalr (push return address).
REQ-017 SHALL have port j_return, in, 1, jr/jalr.
REQ-018 SHALL have port jr_is_ra, in, 1, jr source register is $31.
REQ-019 SHALL have port jr_target, in, 32, forwarded register target.
REQ-020 SHALL have port pc_f, out, 32, current fetch PC (registered).
REQ-021 SHALL have port adel_f, out, 1, fetch address error.
REQ-022 SHALL have port ras_top, out, 32, predicted return address (0 when empty).
REQ-023 SHALL have ports ras_empty / ras_full, out, 1 each, stack status.
REQ-024 SHALL have port ras_hits, out, 16, saturating count of correct RAS predictions.

Function
REQ-025 SHALL compute next PC by priority: req -> HANDLER_PC; eret_d -> epc; j_return -> jr_target; jump -> {pc_d[31:28],imm26,2'b00}; branch_taken -> pc_d+4+sext(imm16)<<2; else pc_f+4.
REQ-026 SHALL load the next PC into pc_f on each rising edge when stall=0; req or eret_d SHALL load regardless of stall.
REQ-027 SHALL perform all adds modulo 2^32, with no overflow detection.
REQ-028 SHALL assert adel_f combinationally when pc_f[1:0]!=0 or pc_f is outside [IM_LO, IM_HI].
REQ-029 SHALL update the RAS only on an accepted cycle (stall=0 and req=0).
REQ-030 SHALL push pc_d+8 when link=1.
REQ-031 SHALL pop when j_return=1 and jr_is_ra=1.
REQ-032 SHALL, on push while full, overwrite the oldest entry circularly; count stays RAS_DEPTH and ras_full stays 1.
REQ-033 SHALL, on pop while empty, leave the stack unchanged.
REQ-034 SHALL, on push and pop in the same cycle, replace the top entry with the pushed value; count unchanged.
REQ-035 SHALL increment ras_hits, saturating at 16'hFFFF, on a pop with ras_empty=0 and ras_top==jr_target.
REQ-036 SHALL set ras_empty = (count==0) and ras_full = (count==RAS_DEPTH).
REQ-037 SHALL take next PC from jr_target only; the RAS is advisory.

Reset
REQ-038 SHALL, when reset=1 at a clock edge, set pc_f=RESET_PC, RAS count=0, pointer=0, ras_hits=0, overriding all other inputs including req.
REQ-039 SHALL hold reset values after reset deasserts: ras_top=0, ras_empty=1, ras_full=0, adel_f=0 (for default parameters).
REQ-040 SHALL discard stack contents on a reset asserted mid-operation, with no residual push or pop.

Structure
REQ-041 SHALL place RESET_PC, HANDLER_PC, IM_LO and IM_HI defaults, and the next-PC-source encoding, in shared package cpu_pkg.
REQ-042 SHALL implement the return-address stack as sub-module ras (circular buffer, count, top read); next-PC mux and PC register stay in pc_gen.

Verification
REQ-043 SHALL verify: reset, then 3 free-run cycles -> pc_f = 3000, 3004, 3008; ras_empty=1.
REQ-044 SHALL verify: pc_d=3010, branch_taken=1, imm16=FFFE -> next pc_f=300C; jump=1 with imm26=0C01 -> pc_f=00003004.
REQ-045 SHALL verify: stall=1 with req=1 -> pc_f=4180; stall=1 alone -> pc_f held; eret_d=1 with epc=3020 -> pc_f=3020.
REQ-046 SHALL verify: link at pc_d=3000, then jr $ra with jr_target=3008 -> ras_top=3008 before the pop, ras_hits=1, ras_empty=1 after.
REQ-047 SHALL verify: 9 pushes with RAS_DEPTH=8 -> ras_full=1, top=last pushed; 8 pops -> empty; a 9th pop -> no change, ras_hits unchanged.
REQ-048 SHALL verify: pc_f forced to 3002 via jr_target -> adel_f=1; jr_target=7000 -> adel_f=1; reset mid-sequence -> pc_f=3000 and count=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared fetch-unit constants, next-PC source encoding and address helpers.
package cpu_pkg;

    localparam logic [31:0] RESET_PC_DEF   = 32'h0000_3000;
    localparam logic [31:0] HANDLER_PC_DEF = 32'h0000_4180;
    localparam logic [31:0] IM_LO_DEF      = 32'h0000_3000;
    localparam logic [31:0] IM_HI_DEF      = 32'h0000_6FFC;
    localparam int          RAS_DEPTH_DEF  = 8;

    // Where the next fetch PC comes from; HOLD keeps the current PC on a stall.
    typedef enum logic [2:0] {
        PC_SRC_SEQ     = 3'd0,
        PC_SRC_BRANCH  = 3'd1,
        PC_SRC_JUMP    = 3'd2,
        PC_SRC_JR      = 3'd3,
        PC_SRC_ERET    = 3'd4,
        PC_SRC_HANDLER = 3'd5,
        PC_SRC_HOLD    = 3'd6
    } pc_src_e;

    // Conditional-branch target: delay-slot PC plus the word-scaled signed offset.
    function automatic logic [31:0] branch_target(input logic [31:0] pc_d,
                                                  input logic [15:0] imm16);
        return pc_d + 32'd4 + {{14{imm16[15]}}, imm16, 2'b00};
    endfunction

    // j/jal target: keep the 256 MB region of the D-stage PC.
    function automatic logic [31:0] jump_target(input logic [31:0] pc_d,
                                                input logic [25:0] imm26);
        return {pc_d[31:28], imm26, 2'b00};
    endfunction

    // Fetch address is illegal when misaligned or outside the instruction memory.
    function automatic logic fetch_addr_err(input logic [31:0] pc,
                                            input logic [31:0] lo,
                                            input logic [31:0] hi);
        return (pc[1:0] != 2'b00) || (pc < lo) || (pc > hi);
    endfunction

endpackage

// File: rtl/pc_gen_if.sv
// Bundle between the decode/exception logic (master) and the PC generator (slave).
interface pc_gen_if;
    logic        stall;
    logic        req;
    logic        eret_d;
    logic [31:0] epc;
    logic [31:0] pc_d;
    logic [25:0] imm26;
    logic [15:0] imm16;
    logic        branch_taken;
    logic        jump;
    logic        link;
    logic        j_return;
    logic        jr_is_ra;
    logic [31:0] jr_target;
    logic [31:0] pc_f;
    logic        adel_f;
    logic [31:0] ras_top;
    logic        ras_empty;
    logic        ras_full;
    logic [15:0] ras_hits;

    modport master (
        output stall, req, eret_d, epc, pc_d, imm26, imm16, branch_taken,
               jump, link, j_return, jr_is_ra, jr_target,
        input  pc_f, adel_f, ras_top, ras_empty, ras_full, ras_hits
    );

    modport slave (
        input  stall, req, eret_d, epc, pc_d, imm26, imm16, branch_taken,
               jump, link, j_return, jr_is_ra, jr_target,
        output pc_f, adel_f, ras_top, ras_empty, ras_full, ras_hits
    );
endinterface

// File: rtl/ras.sv
// Return-address stack: circular buffer whose oldest entry is overwritten on overflow.
module ras
    import cpu_pkg::*;
#(
    parameter int DEPTH = RAS_DEPTH_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  logic        pop,
    input  logic [31:0] push_data,
    output logic [31:0] top,
    output logic        empty,
    output logic        full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   mem_q [DEPTH];
    logic [31:0]   mem_d [DEPTH];
    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic [PW-1:0] top_idx_s;

    // ptr_q is the next write slot, so the top entry sits one below it (mod DEPTH).
    always_comb begin
        top_idx_s = ptr_q - PW'(1);
    end

    // Stack update: push+pop rewrites the top, overflow wraps onto the oldest slot.
    always_comb begin
        mem_d   = mem_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        if (push && pop) begin
            mem_d[top_idx_s] = push_data;
        end else if (push) begin
            mem_d[ptr_q] = push_data;
            ptr_d        = ptr_q + PW'(1);
            if (count_q != CW'(DEPTH)) begin
                count_d = count_q + CW'(1);
            end else begin
                count_d = count_q;
            end
        end else if (pop) begin
            if (count_q != CW'(0)) begin
                ptr_d   = top_idx_s;
                count_d = count_q - CW'(1);
            end else begin
                ptr_d   = ptr_q;
                count_d = count_q;
            end
        end else begin
            count_d = count_q;
        end
    end

    // State registers; reset discards every stored return address.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q   <= PW'(0);
            count_q <= CW'(0);
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 32'h0000_0000;
            end
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Status and top read; an empty stack predicts zero.
    always_comb begin
        empty = (count_q == CW'(0));
        full  = (count_q == CW'(DEPTH));
        if (count_q == CW'(0)) begin
            top = 32'h0000_0000;
        end else begin
            top = mem_q[top_idx_s];
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: prioritised next-PC mux, PC register and return-address predictor.
module pc_gen
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
    parameter logic [31:0] HANDLER_PC = HANDLER_PC_DEF,
    parameter logic [31:0] IM_LO      = IM_LO_DEF,
    parameter logic [31:0] IM_HI      = IM_HI_DEF,
    parameter int          RAS_DEPTH  = RAS_DEPTH_DEF
) (
    input  logic    clk,
    input  logic    reset,
    pc_gen_if.slave bus
);

    pc_src_e     pc_src_s;
    logic [31:0] pc_f_q;
    logic [31:0] pc_f_d;
    logic [15:0] hits_q;
    logic [15:0] hits_d;
    logic        accept_s;
    logic        ras_push_s;
    logic        ras_pop_s;
    logic        ras_hit_s;
    logic [31:0] ras_top_s;
    logic        ras_empty_s;
    logic        ras_full_s;

    // Source select: exceptions and eret override a stall, otherwise a stall holds the PC.
    always_comb begin
        pc_src_s = PC_SRC_SEQ;
        if (bus.req) begin
            pc_src_s = PC_SRC_HANDLER;
        end else if (bus.eret_d) begin
            pc_src_s = PC_SRC_ERET;
        end else if (bus.stall) begin
            pc_src_s = PC_SRC_HOLD;
        end else if (bus.j_return) begin
            pc_src_s = PC_SRC_JR;
        end else if (bus.jump) begin
            pc_src_s = PC_SRC_JUMP;
        end else if (bus.branch_taken) begin
            pc_src_s = PC_SRC_BRANCH;
        end else begin
            pc_src_s = PC_SRC_SEQ;
        end
    end

    // Next-PC mux; register returns always use the forwarded target, never the RAS.
    always_comb begin
        pc_f_d = pc_f_q + 32'd4;
        case (pc_src_s)
            PC_SRC_HANDLER: pc_f_d = HANDLER_PC;
            PC_SRC_ERET:    pc_f_d = bus.epc;
            PC_SRC_HOLD:    pc_f_d = pc_f_q;
            PC_SRC_JR:      pc_f_d = bus.jr_target;
            PC_SRC_JUMP:    pc_f_d = jump_target(bus.pc_d, bus.imm26);
            PC_SRC_BRANCH:  pc_f_d = branch_target(bus.pc_d, bus.imm16);
            PC_SRC_SEQ:     pc_f_d = pc_f_q + 32'd4;
            default:        pc_f_d = pc_f_q + 32'd4;
        endcase
    end

    // Fetch PC register.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_f_q <= RESET_PC;
        end else begin
            pc_f_q <= pc_f_d;
        end
    end

    // The stack only moves on cycles the D-stage instruction actually retires from decode.
    always_comb begin
        accept_s   = !bus.stall && !bus.req;
        ras_push_s = accept_s && bus.link;
        ras_pop_s  = accept_s && bus.j_return && bus.jr_is_ra;
        ras_hit_s  = ras_pop_s && !ras_empty_s && (ras_top_s == bus.jr_target);
    end

    ras #(
        .DEPTH(RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (ras_push_s),
        .pop       (ras_pop_s),
        .push_data (bus.pc_d + 32'd8),
        .top       (ras_top_s),
        .empty     (ras_empty_s),
        .full      (ras_full_s)
    );

    // Prediction hit counter, saturating at all-ones.
    always_comb begin
        if (ras_hit_s && (hits_q != 16'hFFFF)) begin
            hits_d = hits_q + 16'd1;
        end else begin
            hits_d = hits_q;
        end
    end

    // Hit counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            hits_q <= 16'h0000;
        end else begin
            hits_q <= hits_d;
        end
    end

    // Drive the bus outputs; the address-error flag is a decode of the registered PC.
    always_comb begin
        bus.pc_f      = pc_f_q;
        bus.adel_f    = fetch_addr_err(pc_f_q, IM_LO, IM_HI);
        bus.ras_top   = ras_top_s;
        bus.ras_empty = ras_empty_s;
        bus.ras_full  = ras_full_s;
        bus.ras_hits  = hits_q;
    end

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: directed scenarios plus randomized traffic against a queue model.
module tb_pc_gen;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    pc_gen_if bus ();

    pc_gen #(
        .RESET_PC   (32'h0000_3000),
        .HANDLER_PC (32'h0000_4180),
        .IM_LO      (32'h0000_3000),
        .IM_HI      (32'h0000_6FFC),
        .RAS_DEPTH  (8)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] pc;
        logic        adel;
        logic [31:0] top;
        logic        empty;
        logic        full;
        logic [15:0] hits;
    } exp_t;

    exp_t        exp_q[$];
    int          vectors     = 0;
    int          miscompares = 0;

    // Reference model state: PC, a plain queue as the stack (back = top), hit count.
    logic [31:0] m_pc;
    logic [31:0] m_stack[$];
    logic [15:0] m_hits;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_step();
        logic        acc;
        logic        psh;
        logic        pp;
        logic [31:0] old_pc;
        if (reset) begin
            m_pc = 32'h0000_3000;
            m_stack.delete();
            m_hits = 16'd0;
        end else begin
            old_pc = m_pc;
            acc = !bus.stall && !bus.req;
            psh = acc && bus.link;
            pp  = acc && bus.j_return && bus.jr_is_ra;
            if (pp && m_stack.size() > 0 && m_stack[$] == bus.jr_target && m_hits != 16'hFFFF)
                m_hits = m_hits + 16'd1;
            if (psh && pp) begin
                if (m_stack.size() > 0) m_stack[m_stack.size()-1] = bus.pc_d + 32'd8;
            end else if (psh) begin
                if (m_stack.size() == 8) void'(m_stack.pop_front());
                m_stack.push_back(bus.pc_d + 32'd8);
            end else if (pp) begin
                if (m_stack.size() > 0) void'(m_stack.pop_back());
            end
            if (bus.req)               m_pc = 32'h0000_4180;
            else if (bus.eret_d)       m_pc = bus.epc;
            else if (bus.stall)        m_pc = old_pc;
            else if (bus.j_return)     m_pc = bus.jr_target;
            else if (bus.jump)         m_pc = (bus.pc_d & 32'hF000_0000) | (32'(bus.imm26) * 32'd4);
            else if (bus.branch_taken) m_pc = bus.pc_d + 32'd4 + 32'($signed(bus.imm16)) * 32'd4;
            else                       m_pc = old_pc + 32'd4;
        end
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        e.pc    = m_pc;
        e.adel  = (m_pc % 4 != 0) || (m_pc < 32'h0000_3000) || (m_pc > 32'h0000_6FFC);
        e.top   = (m_stack.size() == 0) ? 32'h0 : m_stack[$];
        e.empty = (m_stack.size() == 0);
        e.full  = (m_stack.size() == 8);
        e.hits  = m_hits;
        return e;
    endfunction

    // Called at a negedge with inputs set: predict, queue the expectation, advance one cycle.
    task automatic step_cycle();
        model_step();
        exp_q.push_back(model_out());
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        bus.stall = 1'b0; bus.req = 1'b0; bus.eret_d = 1'b0; bus.epc = 32'h0;
        bus.pc_d = 32'h0; bus.imm26 = 26'h0; bus.imm16 = 16'h0; bus.branch_taken = 1'b0;
        bus.jump = 1'b0; bus.link = 1'b0; bus.j_return = 1'b0; bus.jr_is_ra = 1'b0;
        bus.jr_target = 32'h0;
    endtask

    // Monitor: every cycle the PC register updates, pop one expectation and compare.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("sb_pc_f",      bus.pc_f,              e.pc);
            check("sb_adel_f",    32'(bus.adel_f),       32'(e.adel));
            check("sb_ras_top",   bus.ras_top,           e.top);
            check("sb_ras_empty", 32'(bus.ras_empty),    32'(e.empty));
            check("sb_ras_full",  32'(bus.ras_full),     32'(e.full));
            check("sb_ras_hits",  32'(bus.ras_hits),     32'(e.hits));
        end
    end

    initial begin
        clear_inputs();
        reset = 1'b1;
        m_pc = 32'h0;
        m_hits = 16'd0;
        @(negedge clk);
        step_cycle();
        step_cycle();
        reset = 1'b0;

        // Reset values and free-running fetch.
        check("rst_pc", bus.pc_f, 32'h0000_3000);
        check("rst_empty", 32'(bus.ras_empty), 32'd1);
        check("rst_full", 32'(bus.ras_full), 32'd0);
        check("rst_top", bus.ras_top, 32'h0);
        check("rst_adel", 32'(bus.adel_f), 32'd0);
        step_cycle();
        check("run_pc1", bus.pc_f, 32'h0000_3004);
        step_cycle();
        check("run_pc2", bus.pc_f, 32'h0000_3008);
        check("run_empty", 32'(bus.ras_empty), 32'd1);

        // Backward branch and jump.
        bus.pc_d = 32'h0000_3010; bus.branch_taken = 1'b1; bus.imm16 = 16'hFFFE;
        step_cycle();
        check("branch_pc", bus.pc_f, 32'h0000_300C);
        clear_inputs();
        bus.jump = 1'b1; bus.imm26 = 26'h0000C01;
        step_cycle();
        check("jump_pc", bus.pc_f, 32'h0000_3004);

        // Stall interactions with exceptions and eret.
        clear_inputs();
        bus.stall = 1'b1; bus.req = 1'b1;
        step_cycle();
        check("req_stall_pc", bus.pc_f, 32'h0000_4180);
        bus.req = 1'b0;
        step_cycle();
        check("stall_hold_pc", bus.pc_f, 32'h0000_4180);
        clear_inputs();
        bus.eret_d = 1'b1; bus.epc = 32'h0000_3020;
        step_cycle();
        check("eret_pc", bus.pc_f, 32'h0000_3020);

        // jal then jr $ra with a correct prediction.
        clear_inputs();
        bus.link = 1'b1; bus.pc_d = 32'h0000_3000;
        step_cycle();
        check("link_top", bus.ras_top, 32'h0000_3008);
        check("link_nonempty", 32'(bus.ras_empty), 32'd0);
        clear_inputs();
        bus.j_return = 1'b1; bus.jr_is_ra = 1'b1; bus.jr_target = 32'h0000_3008;
        step_cycle();
        check("jr_pc", bus.pc_f, 32'h0000_3008);
        check("jr_hits", 32'(bus.ras_hits), 32'd1);
        check("jr_empty", 32'(bus.ras_empty), 32'd1);

        // Overflow by one, drain, then pop an empty stack.
        clear_inputs();
        for (int i = 0; i < 9; i++) begin
            bus.link = 1'b1; bus.pc_d = 32'h0000_3100 + 32'(4 * i);
            step_cycle();
        end
        check("ovf_full", 32'(bus.ras_full), 32'd1);
        check("ovf_top", bus.ras_top, 32'h0000_3128);
        clear_inputs();
        for (int i = 0; i < 8; i++) begin
            bus.j_return = 1'b1; bus.jr_is_ra = 1'b1; bus.jr_target = 32'h0000_3128 - 32'(4 * i);
            step_cycle();
        end
        check("drain_empty", 32'(bus.ras_empty), 32'd1);
        check("drain_hits", 32'(bus.ras_hits), 32'd9);
        bus.jr_target = 32'h0000_3108;
        step_cycle();
        check("underflow_empty", 32'(bus.ras_empty), 32'd1);
        check("underflow_hits", 32'(bus.ras_hits), 32'd9);

        // Fetch address errors, then reset mid-sequence.
        clear_inputs();
        bus.j_return = 1'b1; bus.jr_target = 32'h0000_3002;
        step_cycle();
        check("misalign_pc", bus.pc_f, 32'h0000_3002);
        check("misalign_adel", 32'(bus.adel_f), 32'd1);
        bus.jr_target = 32'h0000_7000;
        step_cycle();
        check("range_adel", 32'(bus.adel_f), 32'd1);
        clear_inputs();
        bus.link = 1'b1; bus.pc_d = 32'h0000_3200;
        step_cycle();
        step_cycle();
        bus.req = 1'b1; bus.j_return = 1'b1; bus.jr_is_ra = 1'b1;
        reset = 1'b1;
        step_cycle();
        reset = 1'b0;
        clear_inputs();
        check("midrst_pc", bus.pc_f, 32'h0000_3000);
        check("midrst_empty", 32'(bus.ras_empty), 32'd1);
        check("midrst_top", bus.ras_top, 32'h0);
        check("midrst_hits", 32'(bus.ras_hits), 32'd0);

        // Randomized traffic; roughly half the returns target the predicted address.
        for (int n = 0; n < 3000; n++) begin
            reset            = ($urandom_range(0, 199) == 0);
            bus.stall        = ($urandom_range(0, 3) == 0);
            bus.req          = ($urandom_range(0, 31) == 0);
            bus.eret_d       = ($urandom_range(0, 31) == 0);
            bus.epc          = 32'h0000_3000 + 32'($urandom_range(0, 4095)) * 32'd4;
            bus.pc_d         = 32'h0000_3000 + 32'($urandom_range(0, 4095)) * 32'd4;
            bus.imm26        = 26'($urandom);
            bus.imm16        = 16'($urandom);
            bus.branch_taken = ($urandom_range(0, 3) == 0);
            bus.jump         = ($urandom_range(0, 7) == 0);
            bus.link         = ($urandom_range(0, 3) == 0);
            bus.j_return     = ($urandom_range(0, 5) == 0);
            bus.jr_is_ra     = ($urandom_range(0, 1) == 0);
            if ($urandom_range(0, 1) == 0 && m_stack.size() > 0)
                bus.jr_target = m_stack[$];
            else
                bus.jr_target = 32'h0000_3000 + 32'($urandom_range(0, 16383));
            step_cycle();
        end
        reset = 1'b0;
        clear_inputs();
        step_cycle();

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
